// File: rtl/washer_pkg.sv
// Shared types and helpers for the washer payment front-end.
// State encoding, coin denomination codes and the code-to-value mapping.
package washer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    LAUNCH,
    WASHING,
    REFUND
  } state_e;

  typedef enum logic [1:0] {
    COIN_1   = 2'b00,
    COIN_5   = 2'b01,
    COIN_10  = 2'b10,
    COIN_INV = 2'b11
  } coin_code_e;

  function automatic logic [3:0] coin_units(input logic [1:0] code);
    case (code)
      COIN_1:  coin_units = 4'd1;
      COIN_5:  coin_units = 4'd5;
      COIN_10: coin_units = 4'd10;
      default: coin_units = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Coin sensor conditioning: 2-flop synchronisers on the sensor and value,
// then a saturating run-length counter that emits one event per insertion.
module coin_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_raw_i,
  input  logic [1:0] coin_value_i,
  output logic       coin_evt_o,
  output logic [1:0] coin_value_o
);

  localparam int unsigned     CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       raw_sync_q;
  logic [1:0]       val_meta_q;
  logic [1:0]       val_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;

  // The counter parks at CNT_MAX while the sensor stays high, so a held coin
  // fires exactly once; only a low cycle re-arms it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_d = cnt_q;
    evt_d = 1'b0;
    if (!raw_sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
      evt_d = (cnt_q == CNT_FIRE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_sync_q <= '0;
      val_meta_q <= '0;
      val_sync_q <= '0;
      cnt_q      <= '0;
      evt_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the two flops a true shift chain.
      raw_sync_q <= {raw_sync_q[0], coin_raw_i};
      val_meta_q <= coin_value_i;
      val_sync_q <= val_meta_q;
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
    end
  end

  assign coin_evt_o   = evt_q;
  assign coin_value_o = val_sync_q;

endmodule

// File: rtl/coin_credit_ctrl.sv
// Coin credit controller feeding the washer: credit, launch, change and refund.
// Optional inactivity auto-refund in COLLECT when COIN_CREDIT_TIMEOUT_EN is defined.
module coin_credit_ctrl
  import washer_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned CREDIT_W       = 8,
  parameter int unsigned PRICE_SINGLE   = 10,
  parameter int unsigned PRICE_DOUBLE   = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                coin_raw,
  input  logic [1:0]          coin_value,
  input  logic                start_req,
  input  logic                double_req,
  input  logic                cancel_req,
  input  logic                wash_done,
  output logic                coin_in,
  output logic                double_wash,
  output logic [CREDIT_W-1:0] credit,
  output logic                refund_pulse,
  output logic [CREDIT_W-1:0] refund_amount,
  output logic                coin_reject,
  output logic                ready
);

  localparam logic [CREDIT_W-1:0] PRICE_S = CREDIT_W'(PRICE_SINGLE);
  localparam logic [CREDIT_W-1:0] PRICE_D = CREDIT_W'(PRICE_DOUBLE);

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q, change_q;
  logic                double_sel_q, wash_done_q;
  logic                coin_in_q, double_wash_q, refund_pulse_q, coin_reject_q, ready_q;
  logic [CREDIT_W-1:0] refund_amount_q;

  logic                coin_evt;
  logic [1:0]          coin_code;
  logic [CREDIT_W:0]   credit_sum;
  logic [CREDIT_W-1:0] credit_add_d, credit_in_d;
  logic                coin_ok, accepting, sel_req, wash_edge, timeout_hit;
  logic [CREDIT_W-1:0] price_req, price_cur;

  coin_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk         (CLK),
    .rst_n       (rst_n),
    .coin_raw_i  (coin_raw),
    .coin_value_i(coin_value),
    .coin_evt_o  (coin_evt),
    .coin_value_o(coin_code)
  );

  assign accepting    = (state_q == IDLE) || (state_q == COLLECT);
  assign coin_ok      = coin_evt && (coin_code != COIN_INV);
  assign credit_sum   = {1'b0, credit_q} + {1'b0, CREDIT_W'(coin_units(coin_code))};
  assign credit_add_d = credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];
  assign credit_in_d  = coin_ok ? credit_add_d : credit_q;
  // A double request in the same cycle as start already prices the wash.
  assign sel_req      = double_sel_q | double_req;
  assign price_req    = sel_req ? PRICE_D : PRICE_S;
  assign price_cur    = double_sel_q ? PRICE_D : PRICE_S;
  assign wash_edge    = wash_done && !wash_done_q;

`ifdef COIN_CREDIT_TIMEOUT_EN
  localparam int unsigned    TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] idle_cnt_q;
  logic            activity;

  assign activity    = coin_evt | start_req | double_req | cancel_req;
  assign timeout_hit = (state_q == COLLECT) && !activity && (idle_cnt_q == TO_MAX);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else if ((state_q != COLLECT) || activity) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != TO_MAX) begin
      idle_cnt_q <= idle_cnt_q + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      change_q        <= '0;
      double_sel_q    <= 1'b0;
      wash_done_q     <= 1'b0;
      coin_in_q       <= 1'b0;
      double_wash_q   <= 1'b0;
      refund_pulse_q  <= 1'b0;
      refund_amount_q <= '0;
      coin_reject_q   <= 1'b0;
      ready_q         <= 1'b1;
    end else begin
      wash_done_q     <= wash_done;
      coin_in_q       <= 1'b0;
      refund_pulse_q  <= 1'b0;
      refund_amount_q <= '0;
      coin_reject_q   <= coin_evt && ((coin_code == COIN_INV) || !accepting);

      case (state_q)
        IDLE: begin
          if (double_req) double_sel_q <= 1'b1;
          if (coin_ok) begin
            credit_q <= credit_add_d;
            state_q  <= COLLECT;
          end
        end

        COLLECT: begin
          if (double_req) double_sel_q <= 1'b1;
          if (cancel_req || timeout_hit) begin
            state_q         <= REFUND;
            credit_q        <= '0;
            change_q        <= credit_in_d;
            refund_pulse_q  <= 1'b1;
            refund_amount_q <= credit_in_d;
            ready_q         <= 1'b0;
          end else if (start_req && (credit_in_d >= price_req)) begin
            state_q       <= LAUNCH;
            credit_q      <= credit_in_d;
            coin_in_q     <= 1'b1;
            double_wash_q <= sel_req;
            ready_q       <= 1'b0;
          end else begin
            credit_q <= credit_in_d;
          end
        end

        LAUNCH: begin
          change_q <= credit_q - price_cur;
          credit_q <= '0;
          state_q  <= WASHING;
        end

        WASHING: begin
          if (wash_edge) begin
            double_wash_q <= 1'b0;
            if (change_q != '0) begin
              state_q         <= REFUND;
              refund_pulse_q  <= 1'b1;
              refund_amount_q <= change_q;
            end else begin
              state_q      <= IDLE;
              double_sel_q <= 1'b0;
              ready_q      <= 1'b1;
            end
          end
        end

        REFUND: begin
          change_q     <= '0;
          state_q      <= IDLE;
          double_sel_q <= 1'b0;
          ready_q      <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign coin_in       = coin_in_q;
  assign double_wash   = double_wash_q;
  assign credit        = credit_q;
  assign refund_pulse  = refund_pulse_q;
  assign refund_amount = refund_amount_q;
  assign coin_reject   = coin_reject_q;
  assign ready         = ready_q;

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Randomised bench for coin_credit_ctrl against a transaction-level credit model.
module tb_coin_credit_ctrl;

  localparam int DEB_CYCLES   = 4;
  localparam int CREDIT_W     = 8;
  localparam int PRICE_SINGLE = 10;
  localparam int PRICE_DOUBLE = 15;
  localparam int CREDIT_MAX   = 255;
  localparam int COIN_LAT     = 2 + DEB_CYCLES + 1;  // raw rise to visible credit/reject

  logic                CLK = 1'b0;
  logic                rst_n, coin_raw, start_req, double_req, cancel_req, wash_done;
  logic [1:0]          coin_value;
  logic                coin_in, double_wash, refund_pulse, coin_reject, ready;
  logic [CREDIT_W-1:0] credit, refund_amount;

  coin_credit_ctrl #(
    .DEB_CYCLES    (DEB_CYCLES),
    .CREDIT_W      (CREDIT_W),
    .PRICE_SINGLE  (PRICE_SINGLE),
    .PRICE_DOUBLE  (PRICE_DOUBLE),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .coin_raw     (coin_raw),
    .coin_value   (coin_value),
    .start_req    (start_req),
    .double_req   (double_req),
    .cancel_req   (cancel_req),
    .wash_done    (wash_done),
    .coin_in      (coin_in),
    .double_wash  (double_wash),
    .credit       (credit),
    .refund_pulse (refund_pulse),
    .refund_amount(refund_amount),
    .coin_reject  (coin_reject),
    .ready        (ready)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Observed-event counters, updated once per cycle by tick().
  int                  n_launch = 0, n_refund = 0, n_reject = 0, n_credit_chg = 0;
  logic                launch_dw = 1'b0;
  logic [CREDIT_W-1:0] refund_amt = '0, prev_credit = '0;

  // Reference model: credit, busy (washing or paying out), program choice, change.
  int m_credit = 0;
  bit m_busy   = 1'b0;
  bit m_sel    = 1'b0;
  int m_change = 0;

  function automatic int coin_val(input int code);
    case (code)
      0:       return 1;
      1:       return 5;
      2:       return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int price_of(input bit sel);
    return sel ? PRICE_DOUBLE : PRICE_SINGLE;
  endfunction

  task automatic tick();
    @(negedge CLK);
    if (coin_in === 1'b1) begin
      n_launch++;
      launch_dw = double_wash;
    end
    if (refund_pulse === 1'b1) begin
      n_refund++;
      refund_amt = refund_amount;
    end else begin
      checks++;
      if (refund_amount !== '0) begin
        errors++;
        $display("FAIL refund_idle: refund_amount=%0d expected 0 at %0t", refund_amount, $time);
      end
    end
    if (coin_reject === 1'b1) n_reject++;
    if (credit !== prev_credit) n_credit_chg++;
    prev_credit = credit;
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_busy   = 1'b0;
    m_sel    = 1'b0;
    m_change = 0;
  endtask

  task automatic drop_coin(input int code, input int bounce);
    int rej0, chg0, lat, exp_credit, exp_events, events;
    bit exp_rej;
    exp_rej    = (code == 3) || m_busy;
    exp_credit = exp_rej ? m_credit : ((m_credit + coin_val(code) > CREDIT_MAX) ? CREDIT_MAX : m_credit + coin_val(code));
    exp_events = (exp_rej || exp_credit != m_credit) ? 1 : 0;
    coin_value = 2'(code);
    coin_raw   = 1'b0;
    for (int i = 0; i < bounce; i++) begin
      coin_raw = ~coin_raw;
      tick();
    end
    coin_raw = 1'b1;
    rej0 = n_reject;
    chg0 = n_credit_chg;
    lat  = -1;
    for (int k = 1; k <= DEB_CYCLES + 6; k++) begin
      tick();
      if (lat < 0 && (n_reject != rej0 || n_credit_chg != chg0)) lat = k;
    end
    coin_raw = 1'b0;
    repeat (3) tick();
    events = (n_reject - rej0) + (n_credit_chg - chg0);
    checks++;
    if (credit !== CREDIT_W'(exp_credit)) begin
      errors++;
      $display("FAIL coin_credit: credit=%0d expected %0d (code %0d)", credit, exp_credit, code);
    end
    checks++;
    if ((n_reject - rej0) != int'(exp_rej)) begin
      errors++;
      $display("FAIL coin_reject: rejects=%0d expected %0d (code %0d)", n_reject - rej0, exp_rej, code);
    end
    checks++;
    if (events != exp_events) begin
      errors++;
      $display("FAIL coin_events: events=%0d expected %0d (code %0d)", events, exp_events, code);
    end
    if (exp_events == 1) begin
      checks++;
      if (lat != COIN_LAT) begin
        errors++;
        $display("FAIL coin_latency: cycles=%0d expected %0d", lat, COIN_LAT);
      end
    end
    m_credit = exp_credit;
  endtask

  task automatic press_double();
    if (!m_busy) m_sel = 1'b1;
    double_req = 1'b1;
    tick();
    double_req = 1'b0;
    tick();
  endtask

  task automatic press_start();
    int  n0;
    bit  exp;
    exp = !m_busy && m_credit > 0 && m_credit >= price_of(m_sel);
    n0  = n_launch;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    tick();
    tick();
    checks++;
    if ((n_launch - n0) != int'(exp)) begin
      errors++;
      $display("FAIL launch_count: launches=%0d expected %0d (credit %0d)", n_launch - n0, exp, m_credit);
    end
    if (exp) begin
      checks++;
      if (launch_dw !== m_sel) begin
        errors++;
        $display("FAIL launch_double: double_wash=%0b expected %0b", launch_dw, m_sel);
      end
      m_change = m_credit - price_of(m_sel);
      m_credit = 0;
      m_busy   = 1'b1;
    end
    checks++;
    if (credit !== CREDIT_W'(m_credit) || ready !== !m_busy) begin
      errors++;
      $display("FAIL after_start: credit=%0d ready=%0b expected %0d/%0b", credit, ready, m_credit, !m_busy);
    end
  endtask

  task automatic press_cancel();
    int n0;
    bit exp;
    exp = !m_busy && m_credit > 0;
    n0  = n_refund;
    cancel_req = 1'b1;
    tick();
    cancel_req = 1'b0;
    tick();
    checks++;
    if ((n_refund - n0) != int'(exp)) begin
      errors++;
      $display("FAIL cancel_refund: pulses=%0d expected %0d", n_refund - n0, exp);
    end
    if (exp) begin
      checks++;
      if (refund_amt !== CREDIT_W'(m_credit)) begin
        errors++;
        $display("FAIL cancel_amount: refund=%0d expected %0d", refund_amt, m_credit);
      end
      m_credit = 0;
      m_sel    = 1'b0;
    end
    checks++;
    if (credit !== CREDIT_W'(m_credit) || ready !== 1'b1) begin
      errors++;
      $display("FAIL after_cancel: credit=%0d ready=%0b expected %0d/1", credit, ready, m_credit);
    end
  endtask

  task automatic finish_wash(input int delay);
    int n0;
    repeat (delay) tick();
    checks++;
    if (double_wash !== m_sel || ready !== 1'b0) begin
      errors++;
      $display("FAIL wash_hold: double_wash=%0b ready=%0b expected %0b/0", double_wash, ready, m_sel);
    end
    n0 = n_refund;
    wash_done = 1'b1;
    tick();
    checks++;
    if (double_wash !== 1'b0) begin
      errors++;
      $display("FAIL wash_drop: double_wash=%0b expected 0", double_wash);
    end
    tick();
    checks++;
    if ((n_refund - n0) != int'(m_change > 0)) begin
      errors++;
      $display("FAIL change_count: pulses=%0d expected %0d", n_refund - n0, m_change > 0);
    end
    if (m_change > 0) begin
      checks++;
      if (refund_amt !== CREDIT_W'(m_change)) begin
        errors++;
        $display("FAIL change_amount: refund=%0d expected %0d", refund_amt, m_change);
      end
    end
    checks++;
    if (ready !== 1'b1 || credit !== '0) begin
      errors++;
      $display("FAIL after_wash: ready=%0b credit=%0d expected 1/0", ready, credit);
    end
    wash_done = 1'b0;
    tick();
    m_busy   = 1'b0;
    m_sel    = 1'b0;
    m_change = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; coin_raw = 1'b0; coin_value = 2'b00;
    start_req = 1'b0; double_req = 1'b0; cancel_req = 1'b0; wash_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    model_reset();
    checks++;
    if (credit !== '0 || ready !== 1'b1 || coin_in !== 1'b0 || double_wash !== 1'b0 ||
        refund_pulse !== 1'b0 || coin_reject !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: credit=%0d ready=%0b coin_in=%0b dw=%0b refund=%0b reject=%0b",
               credit, ready, coin_in, double_wash, refund_pulse, coin_reject);
    end
  endtask

  task automatic test_single_wash();
    int order[3];
    int j, t;
    order = '{2, 1, 0};
    for (int i = 2; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 3; i++) drop_coin(order[i], 2 * $urandom_range(0, 2));
    checks++;
    if (credit !== 8'd16) begin
      errors++;
      $display("FAIL single_credit: credit=%0d expected 16", credit);
    end
    press_start();
    finish_wash($urandom_range(1, 5));
  endtask

  task automatic test_double_wash();
    int n0;
    press_double();
    drop_coin(2, 0);
    drop_coin(1, 0);
    wash_done = 1'b1;
    press_start();
    n0 = n_refund;
    repeat (4) tick();
    checks++;
    if (ready !== 1'b0 || double_wash !== 1'b1 || n_refund != n0) begin
      errors++;
      $display("FAIL done_level_ignored: ready=%0b dw=%0b pulses=%0d expected 0/1/0",
               ready, double_wash, n_refund - n0);
    end
    wash_done = 1'b0;
    tick();
    finish_wash(2);
  endtask

  task automatic test_bounce();
    drop_coin(1, 10);
    press_cancel();
  endtask

  task automatic test_reject();
    drop_coin(1, 0);
    drop_coin(3, 2);
    drop_coin(2, 0);
    press_start();
    drop_coin(2, 0);
    finish_wash(1);
  endtask

  task automatic test_cancel();
    int n0, l0;
    drop_coin(1, 0); drop_coin(0, 0); drop_coin(0, 0);
    press_cancel();
    drop_coin(1, 0);
    for (int i = 0; i < 4; i++) drop_coin(0, 0);
    press_start();
    press_cancel();
    drop_coin(2, 0); drop_coin(2, 0);
    n0 = n_refund; l0 = n_launch;
    start_req = 1'b1; cancel_req = 1'b1;
    tick();
    start_req = 1'b0; cancel_req = 1'b0;
    tick();
    checks++;
    if (n_launch != l0 || n_refund - n0 != 1 || refund_amt !== CREDIT_W'(m_credit)) begin
      errors++;
      $display("FAIL cancel_priority: launches=%0d refunds=%0d amount=%0d expected 0/1/%0d",
               n_launch - l0, n_refund - n0, refund_amt, m_credit);
    end
    m_credit = 0;
    m_sel    = 1'b0;
  endtask

  task automatic test_saturation_reset();
    int n0;
    for (int i = 0; i < 27; i++) drop_coin(2, 0);
    checks++;
    if (credit !== 8'd255) begin
      errors++;
      $display("FAIL saturation: credit=%0d expected 255", credit);
    end
    press_start();
    tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (credit !== '0 || ready !== 1'b1 || coin_in !== 1'b0 || double_wash !== 1'b0 ||
        refund_pulse !== 1'b0 || refund_amount !== '0 || coin_reject !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: credit=%0d ready=%0b dw=%0b refund=%0b",
               credit, ready, double_wash, refund_pulse);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    model_reset();
    n0 = n_refund;
    repeat (4) tick();
    checks++;
    if (n_refund != n0 || credit !== '0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_payout: pulses=%0d credit=%0d ready=%0b expected 0/0/1",
               n_refund - n0, credit, ready);
    end
  endtask

  task automatic test_random();
    bit launched;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) press_double();
      for (int c = 0; c < int'($urandom_range(1, 5)); c++)
        drop_coin($urandom_range(0, 3), 2 * $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        press_cancel();
      end else begin
        press_start();
        launched = m_busy;
        if (launched) finish_wash($urandom_range(0, 6));
        else press_cancel();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_wash();
    test_double_wash();
    test_bounce();
    test_reject();
    test_cancel();
    test_saturation_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
